// File: rtl/ufm_pkg.sv
// Shared UFM definitions used by the UFM reader and the burst fetcher.
package ufm_pkg;

  localparam int unsigned UFM_ADDR_W = 15;
  localparam int unsigned UFM_DATA_W = 8;

  typedef logic [UFM_ADDR_W-1:0] ufm_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word fall-through FIFO; head is valid whenever count != 0.
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ufm_burst_fetcher.sv
// Walks consecutive UFM byte addresses, one request outstanding at a time,
// and streams the returned bytes to a consumer through a small FWFT FIFO.
module ufm_burst_fetcher
  import ufm_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = UFM_ADDR_W,
  parameter int unsigned LEN_W  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [LEN_W-1:0]      length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [UFM_DATA_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     ufm_addr,
  output logic                  read_en,
  input  logic [UFM_DATA_W-1:0] ufm_data,
  input  logic                  ufm_valid
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  fetch_state_t      state_d;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  rem_d;
  logic [ADDR_W-1:0] addr_d;
  logic              read_en_d;
  logic              done_d;
  logic              busy_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_d;
  logic              fifo_empty;
  logic              fifo_full;
  logic              flush;
  logic              accept;
  logic              push;
  logic              pop;

  // Abort wins over a coincident response or pop.
  assign flush     = abort && (state != IDLE);
  assign accept    = read_en && ufm_valid;
  assign push      = accept && !flush && !fifo_full;
  assign pop       = out_valid && out_ready && !flush;
  assign out_valid = !fifo_empty;
  assign count_d   = flush ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UFM_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ufm_data),
    .pop       (pop),
    .flush     (flush),
    .head      (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    state_d = state;
    rem_d   = rem;
    addr_d  = ufm_addr;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d = FETCH;
            rem_d   = length;
            addr_d  = start_addr;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (accept) begin
          addr_d = ufm_addr + ADDR_W'(1);
          rem_d  = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort || (pop && fifo_count == CNT_W'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A request only issues with room guaranteed for its response.
    read_en_d = (state_d == FETCH) && (count_d < CNT_W'(DEPTH));
    // Busy covers the done cycle of a real burst, never a zero-length one.
    busy_d    = (state_d != IDLE) || (done_d && state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      ufm_addr <= '0;
      read_en  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      rem      <= rem_d;
      ufm_addr <= addr_d;
      read_en  <= read_en_d;
      done     <= done_d;
      busy     <= busy_d;
    end
  end

endmodule
